// File: rtl/biriscv_mule_if.sv
// Issue and writeback bundle between the core's issue stage and the MULE
// multiply engine. The core drives the opcode fields and consumes accept and
// the writeback beat. The multiply unit is the responder.
interface biriscv_mule_if;
    logic        opcode_valid_i;
    logic [1:0]  opcode_op_i;
    logic [31:0] opcode_ra_operand_i;
    logic [31:0] opcode_rb_operand_i;
    logic [4:0]  opcode_rd_idx_i;
    logic        opcode_accept_o;
    logic        writeback_valid_o;
    logic [4:0]  writeback_rd_idx_o;
    logic [31:0] writeback_value_o;

    // Issue-stage side
    modport master (
        output opcode_valid_i,
        output opcode_op_i,
        output opcode_ra_operand_i,
        output opcode_rb_operand_i,
        output opcode_rd_idx_i,
        input  opcode_accept_o,
        input  writeback_valid_o,
        input  writeback_rd_idx_o,
        input  writeback_value_o
    );

    // Multiply-unit side
    modport slave (
        input  opcode_valid_i,
        input  opcode_op_i,
        input  opcode_ra_operand_i,
        input  opcode_rb_operand_i,
        input  opcode_rd_idx_i,
        output opcode_accept_o,
        output writeback_valid_o,
        output writeback_rd_idx_o,
        output writeback_value_o
    );
endinterface

// File: rtl/biriscv_mule_unit.sv
// MULE: iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Operands are captured as magnitudes plus a result sign. BITS_PER_CYCLE
// multiplier bits are retired per CALC cycle, one FIX cycle applies the sign
// and selects the result half, and a one-cycle writeback strobe follows in DONE.
module biriscv_mule_unit #(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    output logic          busy_o,
    biriscv_mule_if.slave mule_if
);
    localparam int N_ITER = 32 / BITS_PER_CYCLE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Magnitude of a 32-bit operand. 0x80000000 maps onto itself, which is
    // the correct unsigned magnitude.
    function automatic logic [31:0] operand_mag(input logic [31:0] val, input logic is_signed);
        logic [31:0] mag;
        if (is_signed && val[31]) begin
            mag = (~val) + 32'd1;
        end else begin
            mag = val;
        end
        return mag;
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  iter_q, iter_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [33:0] mcand3_q, mcand3_d;
    logic [31:0] mpr_q, mpr_d;
    logic        neg_q, neg_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_value_q, wb_value_d;

    logic        accept_s;
    logic        issue_s;
    logic        ra_signed_s;
    logic        rb_signed_s;
    logic [31:0] ra_mag_s;
    logic [31:0] rb_mag_s;
    logic [35:0] pp_s;
    logic [36:0] sum_s;
    logic [68:0] wide_s;
    logic [63:0] acc_step_s;
    logic [63:0] product_s;

    assign accept_s    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !flush_i;
    assign issue_s     = mule_if.opcode_valid_i && accept_s;
    assign ra_signed_s = (mule_if.opcode_op_i == 2'b01) || (mule_if.opcode_op_i == 2'b10);
    assign rb_signed_s = (mule_if.opcode_op_i == 2'b01);
    assign ra_mag_s    = operand_mag(mule_if.opcode_ra_operand_i, ra_signed_s);
    assign rb_mag_s    = operand_mag(mule_if.opcode_rb_operand_i, rb_signed_s);

    // Partial product of the low multiplier digit and the multiplicand
    always_comb begin
        pp_s = 36'd0;
        if (BITS_PER_CYCLE == 2) begin
            case (mpr_q[1:0])
                2'b00:   pp_s = 36'd0;
                2'b01:   pp_s = {4'd0, mcand_q};
                2'b10:   pp_s = {3'd0, mcand_q, 1'b0};
                2'b11:   pp_s = {2'd0, mcand3_q};
                default: pp_s = 36'd0;
            endcase
        end else begin
            for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                if (mpr_q[j]) begin
                    pp_s = pp_s + ({4'd0, mcand_q} << j);
                end else begin
                    pp_s = pp_s;
                end
            end
        end
    end

    // The digit is added at the top of the accumulator and the whole value
    // shifted right by B, which is equivalent to adding at weight B*iter but
    // avoids a 64-bit barrel shifter. After N_ITER steps acc is the product.
    assign sum_s      = {5'd0, acc_q[63:32]} + {1'b0, pp_s};
    assign wide_s     = {sum_s, acc_q[31:0]};
    assign acc_step_s = 64'(wide_s >> BITS_PER_CYCLE);
    assign product_s  = neg_q ? (64'd0 - acc_q) : acc_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            iter_q     <= 6'd0;
            acc_q      <= 64'd0;
            mcand_q    <= 32'd0;
            mcand3_q   <= 34'd0;
            mpr_q      <= 32'd0;
            neg_q      <= 1'b0;
            op_q       <= 2'd0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_value_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mcand3_q   <= mcand3_d;
            mpr_q      <= mpr_d;
            neg_q      <= neg_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_value_q <= wb_value_d;
        end
    end

    // Next-state, iteration step, result fix-up and operand capture
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mcand3_d   = mcand3_q;
        mpr_d      = mpr_q;
        neg_d      = neg_q;
        op_d       = op_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_value_d = wb_value_q;

        case (state_q)
            ST_IDLE: begin
                state_d = issue_s ? ST_CALC : ST_IDLE;
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d  = acc_step_s;
                    mpr_d  = mpr_q >> BITS_PER_CYCLE;
                    iter_d = iter_q + 6'd1;
                    if (iter_q == 6'(N_ITER - 1)) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_value_d = (op_q == 2'b00) ? product_s[31:0] : product_s[63:32];
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                // A new issue here gives back-to-back operation.
                state_d = issue_s ? ST_CALC : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // issue_s can only be true in IDLE or DONE
        if (issue_s) begin
            iter_d   = 6'd0;
            acc_d    = 64'd0;
            mcand_d  = ra_mag_s;
            mcand3_d = {2'd0, ra_mag_s} + {1'b0, ra_mag_s, 1'b0};
            mpr_d    = rb_mag_s;
            neg_d    = (ra_signed_s && mule_if.opcode_ra_operand_i[31]) ^
                       (rb_signed_s && mule_if.opcode_rb_operand_i[31]);
            op_d     = mule_if.opcode_op_i;
            rd_d     = mule_if.opcode_rd_idx_i;
        end else begin
            op_d = op_d;
        end
    end

    assign busy_o                     = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign mule_if.opcode_accept_o    = accept_s;
    assign mule_if.writeback_valid_o  = wb_valid_q;
    assign mule_if.writeback_rd_idx_o = wb_rd_q;
    assign mule_if.writeback_value_o  = wb_value_q;
endmodule

// File: tb/tb_biriscv_mule_unit.sv
// Directed and reference-model bench for biriscv_mule_unit. Three instances
// (B=1, 2, 4) share clock, reset and flush; directed steps target the B=2 unit.
module tb_biriscv_mule_unit;
    logic clk;
    logic rst;
    logic flush;
    logic busy1, busy2, busy4;
    int   errors;
    int   checks;

    biriscv_mule_if if1 ();
    biriscv_mule_if if2 ();
    biriscv_mule_if if4 ();

    biriscv_mule_unit #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .busy_o(busy1), .mule_if(if1.slave));
    biriscv_mule_unit #(.BITS_PER_CYCLE(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .busy_o(busy2), .mule_if(if2.slave));
    biriscv_mule_unit #(.BITS_PER_CYCLE(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .busy_o(busy4), .mule_if(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M reference: sign-extend per variant, take the 64-bit product.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = ((op == 2'b01) || (op == 2'b10)) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive2(input logic v, input logic [1:0] op, input logic [31:0] ra,
                          input logic [31:0] rb, input logic [4:0] rd);
        if2.opcode_valid_i      = v;
        if2.opcode_op_i         = op;
        if2.opcode_ra_operand_i = ra;
        if2.opcode_rb_operand_i = rb;
        if2.opcode_rd_idx_i     = rd;
    endtask

    // Called at #1 after the issue edge; returns edges until the strobe and
    // the number of sampled cycles with busy high (bounded).
    task automatic wait_strobe2(output int cyc, output int bcnt);
        bcnt = busy2 ? 1 : 0;
        cyc  = 0;
        while (cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (if2.writeback_valid_o) break;
            if (busy2) bcnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] ra,
                          input logic [31:0] rb, input logic [4:0] rd, input logic [31:0] exp);
        int cyc;
        int bcnt;
        @(negedge clk);
        chk({tag, "_accept"}, 64'(if2.opcode_accept_o), 64'd1);
        drive2(1'b1, op, ra, rb, rd);
        @(posedge clk); #1;
        // operands change after issue must not matter
        drive2(1'b0, ~op, ~ra, ~rb, ~rd);
        wait_strobe2(cyc, bcnt);
        chk({tag, "_latency"}, 64'(cyc), 64'd17);
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd17);
        chk({tag, "_rd"}, 64'(if2.writeback_rd_idx_o), 64'(rd));
        chk({tag, "_value"}, 64'(if2.writeback_value_o), 64'(exp));
        @(posedge clk); #1;
        chk({tag, "_strobe_one_cycle"}, 64'(if2.writeback_valid_o), 64'd0);
        chk({tag, "_value_hold"}, 64'(if2.writeback_value_o), 64'(exp));
    endtask

    task automatic count_strobes(input int n, output int s);
        s = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (if2.writeback_valid_o) s++;
        end
    endtask

    initial begin
        int cyc;
        int bcnt;
        int s;
        logic [31:0] corner [5];
        errors = 0;
        checks = 0;
        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

        rst = 1'b1;
        flush = 1'b0;
        drive2(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        if1.opcode_valid_i = 1'b0; if1.opcode_op_i = 2'b00; if1.opcode_rd_idx_i = 5'd0;
        if1.opcode_ra_operand_i = 32'd0; if1.opcode_rb_operand_i = 32'd0;
        if4.opcode_valid_i = 1'b0; if4.opcode_op_i = 2'b00; if4.opcode_rd_idx_i = 5'd0;
        if4.opcode_ra_operand_i = 32'd0; if4.opcode_rb_operand_i = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_wb_valid", 64'(if2.writeback_valid_o), 64'd0);
        chk("reset_wb_rd", 64'(if2.writeback_rd_idx_o), 64'd0);
        chk("reset_wb_value", 64'(if2.writeback_value_o), 64'd0);
        chk("reset_busy", 64'(busy2), 64'd0);
        chk("reset_accept", 64'(if2.opcode_accept_o), 64'd1);

        // Basic variants
        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd13, 32'd42);
        run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        run_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
        run_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
        run_op("mul_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0001);

        // Back-to-back: valid held high so the second issue lands in DONE
        @(negedge clk);
        drive2(1'b1, 2'b00, 32'd100, 32'd200, 5'd7);
        @(posedge clk); #1;
        drive2(1'b1, 2'b01, 32'hFFFF_FFFE, 32'd3, 5'd8);
        wait_strobe2(cyc, bcnt);
        chk("b2b_first_latency", 64'(cyc), 64'd17);
        chk("b2b_first_value", 64'(if2.writeback_value_o), 64'd20000);
        chk("b2b_first_rd", 64'(if2.writeback_rd_idx_o), 64'd7);
        chk("b2b_accept_in_done", 64'(if2.opcode_accept_o), 64'd1);
        @(posedge clk); #1;
        drive2(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        chk("b2b_no_bubble_busy", 64'(busy2), 64'd1);
        wait_strobe2(cyc, bcnt);
        chk("b2b_second_latency", 64'(cyc), 64'd17);
        chk("b2b_second_value", 64'(if2.writeback_value_o), 64'hFFFF_FFFF);
        chk("b2b_second_rd", 64'(if2.writeback_rd_idx_o), 64'd8);

        // Flush during the 5th CALC cycle
        @(posedge clk); #1;
        @(negedge clk);
        drive2(1'b1, 2'b00, 32'd11, 32'd13, 5'd9);
        @(posedge clk); #1;
        drive2(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        chk("flush_calc_busy_before", 64'(busy2), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_calc_busy_after", 64'(busy2), 64'd0);
        count_strobes(25, s);
        chk("flush_calc_no_wb", 64'(s), 64'd0);
        run_op("mul_3x5_after_flush", 2'b00, 32'd3, 32'd5, 5'd4, 32'd15);

        // Flush coincident with valid drops the issue
        @(negedge clk);
        drive2(1'b1, 2'b00, 32'd9, 32'd9, 5'd5);
        flush = 1'b1;
        #1;
        chk("flush_issue_accept", 64'(if2.opcode_accept_o), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        drive2(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        chk("flush_issue_busy", 64'(busy2), 64'd0);
        count_strobes(20, s);
        chk("flush_issue_no_wb", 64'(s), 64'd0);

        // Reset asserted in FIX
        @(negedge clk);
        drive2(1'b1, 2'b00, 32'd9, 32'd9, 5'd6);
        @(posedge clk); #1;
        drive2(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        repeat (16) @(posedge clk);
        #1;
        chk("rst_fix_busy_before", 64'(busy2), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_fix_wb_valid", 64'(if2.writeback_valid_o), 64'd0);
        chk("rst_fix_wb_value", 64'(if2.writeback_value_o), 64'd0);
        chk("rst_fix_wb_rd", 64'(if2.writeback_rd_idx_o), 64'd0);
        chk("rst_fix_busy", 64'(busy2), 64'd0);
        count_strobes(20, s);
        chk("rst_fix_no_wb", 64'(s), 64'd0);

        // Regression against the reference model on B=1, 2 and 4 in parallel
        for (int n = 0; n < 1000; n++) begin
            logic [1:0]  op;
            logic [31:0] ra;
            logic [31:0] rb;
            logic [4:0]  rd;
            logic [31:0] exp;
            int lat1, lat2, lat4;
            logic [31:0] v1, v2, v4;
            logic [4:0]  r1, r2, r4;
            op = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rd = 5'($urandom_range(0, 31));
            exp = ref_mul(op, ra, rb);
            @(negedge clk);
            if1.opcode_valid_i = 1'b1; if1.opcode_op_i = op; if1.opcode_rd_idx_i = rd;
            if1.opcode_ra_operand_i = ra; if1.opcode_rb_operand_i = rb;
            if4.opcode_valid_i = 1'b1; if4.opcode_op_i = op; if4.opcode_rd_idx_i = rd;
            if4.opcode_ra_operand_i = ra; if4.opcode_rb_operand_i = rb;
            drive2(1'b1, op, ra, rb, rd);
            @(posedge clk); #1;
            if1.opcode_valid_i = 1'b0;
            if4.opcode_valid_i = 1'b0;
            drive2(1'b0, op, ra, rb, rd);
            lat1 = 0; lat2 = 0; lat4 = 0;
            v1 = 32'd0; v2 = 32'd0; v4 = 32'd0;
            r1 = 5'd0; r2 = 5'd0; r4 = 5'd0;
            for (int c = 1; c <= 36; c++) begin
                @(posedge clk); #1;
                if (if1.writeback_valid_o && lat1 == 0) begin
                    lat1 = c; v1 = if1.writeback_value_o; r1 = if1.writeback_rd_idx_o;
                end
                if (if2.writeback_valid_o && lat2 == 0) begin
                    lat2 = c; v2 = if2.writeback_value_o; r2 = if2.writeback_rd_idx_o;
                end
                if (if4.writeback_valid_o && lat4 == 0) begin
                    lat4 = c; v4 = if4.writeback_value_o; r4 = if4.writeback_rd_idx_o;
                end
            end
            chk("rand_b1_latency", 64'(lat1), 64'd33);
            chk("rand_b2_latency", 64'(lat2), 64'd17);
            chk("rand_b4_latency", 64'(lat4), 64'd9);
            chk("rand_b1_value", 64'(v1), 64'(exp));
            chk("rand_b2_value", 64'(v2), 64'(exp));
            chk("rand_b4_value", 64'(v4), 64'(exp));
            chk("rand_b1_rd", 64'(r1), 64'(rd));
            chk("rand_b2_rd", 64'(r2), 64'(rd));
            chk("rand_b4_rd", 64'(r4), 64'(rd));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
